// File: rtl/data_mem_ctrl.sv
// Data-memory controller for the MEM stage: fixed-latency word array with
// byte-lane stores, misaligned/out-of-range rejection and a pipeline stall.
module data_mem_ctrl #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        mem_stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        addr_err
);

    localparam int unsigned Depth = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic                    write_q, write_d;
    logic [31:0]             rdata_q;
    logic                    rdata_valid_q;
    logic                    addr_err_q;
    logic [31:0]             mem_q [Depth];

    logic any_req, one_req, addr_ok, accept, reject;
    logic stall_raw, commit_raw, commit;

    assign any_req = req_read | req_write;
    assign one_req = req_read ^ req_write;
    assign addr_ok = (req_addr[1:0] == 2'b00) && (req_addr[31:ADDR_WIDTH+2] == '0);
    assign accept  = (state_q == StIdle) && one_req && addr_ok;
    assign reject  = (state_q == StIdle) && any_req && !(one_req && addr_ok);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        write_d    = write_q;
        stall_raw  = 1'b0;
        commit_raw = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    stall_raw = 1'b1;
                    addr_d    = req_addr[ADDR_WIDTH+1:2];
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    write_d   = req_write;
                    if (LATENCY == 1) begin
                        state_d    = StDone;
                        commit_raw = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(LATENCY - 2);
                    end
                end
            end
            StWait: begin
                stall_raw = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d    = StDone;
                    commit_raw = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Reset must silence the stall and block any commit even while a request is present.
    assign mem_stall = stall_raw & ~rst;
    assign commit    = commit_raw & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= 4'd0;
            addr_q        <= '0;
            wdata_q       <= 32'd0;
            wstrb_q       <= 4'd0;
            write_q       <= 1'b0;
            rdata_q       <= 32'd0;
            rdata_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            write_q       <= write_d;
            rdata_valid_q <= commit & ~write_d;
            addr_err_q    <= reject;
            if (commit && !write_d) begin
                rdata_q <= mem_q[addr_d];
            end
        end
    end

    // Array is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (commit && write_d) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_d[i]) begin
                    mem_q[addr_d][8*i +: 8] <= wdata_d[8*i +: 8];
                end
            end
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: transaction-level reference model plus
// directed scenarios on a LATENCY=2 instance and a LATENCY=1 instance.
module tb_data_mem_ctrl;

    localparam int Lat = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_read = 1'b0, req_write = 1'b0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic [3:0]  req_wstrb = 4'd0;
    logic        mem_stall, rdata_valid, addr_err;
    logic [31:0] rdata;

    logic        r1_read = 1'b0, r1_write = 1'b0;
    logic [31:0] r1_addr = 32'd0, r1_wdata = 32'd0;
    logic [3:0]  r1_wstrb = 4'd0;
    logic        s1_stall, s1_valid, s1_err;
    logic [31:0] s1_rdata;

    int errors = 0;
    int checks = 0;

    data_mem_ctrl #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut (
        .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .mem_stall(mem_stall), .rdata(rdata), .rdata_valid(rdata_valid), .addr_err(addr_err)
    );

    data_mem_ctrl #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_read(r1_read), .req_write(r1_write),
        .req_addr(r1_addr), .req_wdata(r1_wdata), .req_wstrb(r1_wstrb),
        .mem_stall(s1_stall), .rdata(s1_rdata), .rdata_valid(s1_valid), .addr_err(s1_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit addr_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:12] == 20'd0);
    endfunction

    // Reference model: a stall countdown per accepted access and a byte-level memory image.
    logic [31:0] mem_m [1024];
    logic [3:0]  kn_m  [1024];
    int          wait_left = 0;
    bit          in_done = 0;
    bit          exp_valid = 0, exp_err = 0, rdata_known = 1;
    logic [31:0] exp_rdata = 32'd0;
    bit          op_wr;
    int          op_idx;
    logic [31:0] op_d;
    logic [3:0]  op_s;

    initial for (int i = 0; i < 1024; i++) kn_m[i] = 4'd0;

    always @(negedge clk) begin
        bit idle, legal, illegal, commit;
        if (rst) begin
            check("rst_stall", mem_stall, 0);
            check("rst_valid", rdata_valid, 0);
            check("rst_err", addr_err, 0);
            check("rst_rdata", rdata, 0);
            wait_left = 0; in_done = 0; exp_valid = 0; exp_err = 0;
            exp_rdata = 32'd0; rdata_known = 1;
        end else begin
            idle    = (wait_left == 0) && !in_done;
            legal   = idle && (req_read ^ req_write) && addr_legal(req_addr);
            illegal = idle && (req_read | req_write) && !legal;
            check("m_stall", mem_stall, (wait_left > 0) || legal);
            check("m_valid", rdata_valid, exp_valid);
            check("m_err", addr_err, exp_err);
            if (rdata_known) check("m_rdata", rdata, exp_rdata);
            exp_err = illegal; exp_valid = 0; in_done = 0; commit = 0;
            if (legal) begin
                op_wr = req_write; op_idx = int'(req_addr[11:2]);
                op_d = req_wdata; op_s = req_wstrb;
                wait_left = Lat - 1;
                commit = (wait_left == 0);
            end else if (wait_left > 0) begin
                wait_left--;
                commit = (wait_left == 0);
            end
            if (commit) begin
                in_done = 1;
                if (op_wr) begin
                    for (int b = 0; b < 4; b++)
                        if (op_s[b]) begin
                            mem_m[op_idx][8*b +: 8] = op_d[8*b +: 8];
                            kn_m[op_idx][b] = 1'b1;
                        end
                end else begin
                    exp_rdata = mem_m[op_idx];
                    rdata_known = (kn_m[op_idx] == 4'hF);
                    exp_valid = 1;
                end
            end
        end
    end

    // Called at posedge+1; drops the request after the DONE cycle (or after one cycle if rejected).
    task automatic access(input bit sel, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s, output int stalls,
                          output int valids, output int errs, output logic [31:0] data);
        bit done = 0;
        logic st, v, e;
        logic [31:0] ro;
        stalls = 0; valids = 0; errs = 0; data = 32'd0;
        if (sel) begin
            r1_read = rd; r1_write = wr; r1_addr = a; r1_wdata = d; r1_wstrb = s;
        end else begin
            req_read = rd; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
        end
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            st = sel ? s1_stall : mem_stall;
            v  = sel ? s1_valid : rdata_valid;
            e  = sel ? s1_err : addr_err;
            ro = sel ? s1_rdata : rdata;
            stalls += int'(st); valids += int'(v); errs += int'(e);
            if (v) data = ro;
            if (!st) done = 1;
            @(posedge clk); #1;
        end
        if (!done) check("access_timeout", 0, 1);
        r1_read = 0; r1_write = 0; req_read = 0; req_write = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            st = sel ? s1_stall : mem_stall;
            v  = sel ? s1_valid : rdata_valid;
            e  = sel ? s1_err : addr_err;
            stalls += int'(st); valids += int'(v); errs += int'(e);
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [31:0] pick_addr();
        int unsigned k = $urandom % 8;
        int unsigned idx;
        case (k)
            0: idx = 0;     1: idx = 1;   2: idx = 2;   3: idx = 41;
            4: idx = 4;     5: idx = 511; 6: idx = 512; default: idx = 1023;
        endcase
        return {20'd0, idx[9:0], 2'b00};
    endfunction

    initial begin
        int st, vl, er;
        logic [31:0] dt;
        logic [5:0] stall_v, valid_v;
        #1 rst = 1;
        #1;
        check("rst0_stall", mem_stall, 0);
        check("rst0_rdata", rdata, 0);
        check("rst0_valid", rdata_valid, 0);
        check("rst0_err", addr_err, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;

        access(0, 0, 1, 32'h0, 32'h01020304, 4'hF, st, vl, er, dt);
        access(0, 0, 1, 32'hA4, 32'hDEADBEEF, 4'hF, st, vl, er, dt);
        check("st_stalls", st, 2);
        check("st_errs", er, 0);
        access(0, 1, 0, 32'hA4, 32'h0, 4'h0, st, vl, er, dt);
        check("ld_stalls", st, 2);
        check("ld_valids", vl, 1);
        check("ld_data", dt, 32'hDEADBEEF);

        access(0, 0, 1, 32'h8, 32'h11223344, 4'hF, st, vl, er, dt);
        access(0, 0, 1, 32'h8, 32'hAABBCCDD, 4'b0101, st, vl, er, dt);
        access(0, 1, 0, 32'h8, 32'h0, 4'h0, st, vl, er, dt);
        check("strb_data", dt, 32'h11BB33DD);

        access(0, 1, 0, 32'h6, 32'h0, 4'h0, st, vl, er, dt);
        check("mis_errs", er, 1);
        check("mis_stalls", st, 0);
        check("mis_valids", vl, 0);
        access(0, 0, 1, 32'h1000, 32'hFFFFFFFF, 4'hF, st, vl, er, dt);
        check("oor_errs", er, 1);
        check("oor_stalls", st, 0);
        access(0, 0, 1, 32'h0, 32'hFFFFFFFF, 4'h0, st, vl, er, dt);
        check("zstrb_stalls", st, 2);
        access(0, 1, 0, 32'h0, 32'h0, 4'h0, st, vl, er, dt);
        check("unchanged_data", dt, 32'h01020304);

        // Load held continuously: must be re-accepted only after DONE returns to IDLE.
        req_read = 1; req_addr = 32'hA4;
        for (int c = 5; c >= 0; c--) begin
            @(negedge clk);
            stall_v[c] = mem_stall;
            valid_v[c] = rdata_valid;
            @(posedge clk); #1;
        end
        req_read = 0;
        check("held_stall", 32'(stall_v), 32'b110110);
        check("held_valid", 32'(valid_v), 32'b001001);
        check("held_data", rdata, 32'hDEADBEEF);
        repeat (2) @(posedge clk);
        #1;

        access(0, 0, 1, 32'h10, 32'h5555AAAA, 4'hF, st, vl, er, dt);
        req_write = 1; req_addr = 32'h10; req_wdata = 32'h12345678; req_wstrb = 4'hF;
        @(posedge clk); #1;
        check("wait_stall", mem_stall, 1);
        #1 rst = 1; req_write = 0;
        #1;
        check("arst_stall", mem_stall, 0);
        check("arst_rdata", rdata, 0);
        check("arst_valid", rdata_valid, 0);
        check("arst_err", addr_err, 0);
        @(negedge clk);
        @(posedge clk); #1 rst = 0;
        access(0, 1, 0, 32'h10, 32'h0, 4'h0, st, vl, er, dt);
        check("abort_data", dt, 32'h5555AAAA);

        access(1, 0, 1, 32'h20, 32'hCAFEF00D, 4'hF, st, vl, er, dt);
        check("l1_st_stalls", st, 1);
        access(1, 1, 0, 32'h20, 32'h0, 4'h0, st, vl, er, dt);
        check("l1_ld_stalls", st, 1);
        check("l1_ld_valids", vl, 1);
        check("l1_ld_data", dt, 32'hCAFEF00D);
        access(1, 1, 1, 32'h20, 32'h0, 4'hF, st, vl, er, dt);
        check("l1_both_errs", er, 1);
        check("l1_both_stalls", st, 0);
        check("l1_both_valids", vl, 0);

        for (int n = 0; n < 3000; n++) begin
            int unsigned r = $urandom % 16;
            req_read  = (r < 5) || (r == 10) || (r == 11);
            req_write = (r >= 5 && r < 10) || (r == 10) || (r == 12);
            req_addr  = pick_addr();
            if (r == 11) req_addr = req_addr | 32'($urandom % 3 + 1);
            if (r == 12) req_addr = req_addr | (32'h1 << (12 + $urandom % 20));
            req_wdata = $urandom;
            req_wstrb = 4'($urandom);
            rst = ($urandom % 150 == 0);
            @(posedge clk); #1;
        end
        req_read = 0; req_write = 0; rst = 0;
        repeat (4) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
